// File: rtl/register_scoreboard.sv
// Pending-write scoreboard beside decode: one saturating in-flight counter per
// architectural register, producing the decode stall and a sticky underflow flag.
module register_scoreboard #(
    parameter int REGISTER_INDEX_WIDTH = 5,
    parameter int NUM_REGISTERS        = 32,
    parameter int MAX_PENDING          = 3,
    parameter int WB_BYPASS            = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            decode_valid,
    input  logic                            decode_uses_src_1,
    input  logic                            decode_uses_src_2,
    input  logic [REGISTER_INDEX_WIDTH-1:0] decode_idx_src_1,
    input  logic [REGISTER_INDEX_WIDTH-1:0] decode_idx_src_2,
    input  logic                            decode_writes_dst,
    input  logic [REGISTER_INDEX_WIDTH-1:0] decode_idx_dst,
    input  logic                            wb_valid,
    input  logic [REGISTER_INDEX_WIDTH-1:0] wb_idx_dst,
    input  logic                            flush,
    output logic                            stall,
    output logic [NUM_REGISTERS-1:0]        busy_mask,
    output logic                            underflow_err
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    logic [CNT_W-1:0] count_q [1:NUM_REGISTERS-1];
    logic [CNT_W-1:0] count_d [1:NUM_REGISTERS-1];
    logic             underflow_q;
    logic             underflow_d;

    logic src_hazard;
    logic dst_full;
    logic issue;
    logic retire;

    // Mux-based lookup so x0 and indices beyond NUM_REGISTERS read as zero.
    function automatic logic [CNT_W-1:0] count_of(input logic [REGISTER_INDEX_WIDTH-1:0] idx);
        count_of = '0;
        for (int r = 1; r < NUM_REGISTERS; r++) begin
            if (idx == REGISTER_INDEX_WIDTH'(r)) count_of = count_q[r];
        end
    endfunction

    function automatic logic released(input logic [REGISTER_INDEX_WIDTH-1:0] idx);
        released = (WB_BYPASS != 0) && wb_valid && (wb_idx_dst == idx)
                   && (count_of(idx) == CNT_W'(1));
    endfunction

    function automatic logic src_pending(input logic                            uses,
                                         input logic [REGISTER_INDEX_WIDTH-1:0] idx);
        src_pending = uses && (idx != '0) && (count_of(idx) != '0) && !released(idx);
    endfunction

    always_comb begin
        src_hazard = decode_valid
                     && (src_pending(decode_uses_src_1, decode_idx_src_1)
                         || src_pending(decode_uses_src_2, decode_idx_src_2));
        // A same-cycle write-back to the destination keeps its count unchanged,
        // so a saturated counter does not block issue in that cycle.
        dst_full   = decode_valid && decode_writes_dst && (decode_idx_dst != '0)
                     && (count_of(decode_idx_dst) == CNT_W'(MAX_PENDING))
                     && !(wb_valid && (wb_idx_dst == decode_idx_dst));
        stall      = (src_hazard || dst_full) && !flush;
        issue      = decode_valid && decode_writes_dst && (decode_idx_dst != '0)
                     && !stall && !flush;
        retire     = wb_valid && (wb_idx_dst != '0) && !flush;
    end

    always_comb begin
        underflow_d = underflow_q || (retire && (count_of(wb_idx_dst) == '0));
        for (int r = 1; r < NUM_REGISTERS; r++) begin
            count_d[r] = count_q[r];
            if (flush) begin
                count_d[r] = '0;
            end else begin
                if (issue && (decode_idx_dst == REGISTER_INDEX_WIDTH'(r))
                    && !(retire && (wb_idx_dst == REGISTER_INDEX_WIDTH'(r)))) begin
                    count_d[r] = count_q[r] + CNT_W'(1);
                end else if (retire && (wb_idx_dst == REGISTER_INDEX_WIDTH'(r))
                             && !(issue && (decode_idx_dst == REGISTER_INDEX_WIDTH'(r)))
                             && (count_q[r] != '0)) begin
                    count_d[r] = count_q[r] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < NUM_REGISTERS; r++) begin
            busy_mask[r] = (count_q[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NUM_REGISTERS; r++) count_q[r] <= '0;
            underflow_q <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGISTERS; r++) count_q[r] <= count_d[r];
            underflow_q <= underflow_d;
        end
    end

    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Bench for register_scoreboard: a bypass and a non-bypass instance share stimulus;
// table vectors go through an expectation queue, plus a hand-written mid-stall reset.
module tb_register_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        decode_valid, decode_uses_src_1, decode_uses_src_2;
    logic [4:0]  decode_idx_src_1, decode_idx_src_2, decode_idx_dst;
    logic        decode_writes_dst, wb_valid, flush;
    logic [4:0]  wb_idx_dst;
    logic        stall_b, stall_n, uf_b, uf_n;
    logic [31:0] busy_b, busy_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    register_scoreboard #(.REGISTER_INDEX_WIDTH(5), .NUM_REGISTERS(32), .MAX_PENDING(3), .WB_BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .decode_valid(decode_valid),
        .decode_uses_src_1(decode_uses_src_1), .decode_uses_src_2(decode_uses_src_2),
        .decode_idx_src_1(decode_idx_src_1), .decode_idx_src_2(decode_idx_src_2),
        .decode_writes_dst(decode_writes_dst), .decode_idx_dst(decode_idx_dst),
        .wb_valid(wb_valid), .wb_idx_dst(wb_idx_dst), .flush(flush),
        .stall(stall_b), .busy_mask(busy_b), .underflow_err(uf_b));

    register_scoreboard #(.REGISTER_INDEX_WIDTH(5), .NUM_REGISTERS(32), .MAX_PENDING(3), .WB_BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .decode_valid(decode_valid),
        .decode_uses_src_1(decode_uses_src_1), .decode_uses_src_2(decode_uses_src_2),
        .decode_idx_src_1(decode_idx_src_1), .decode_idx_src_2(decode_idx_src_2),
        .decode_writes_dst(decode_writes_dst), .decode_idx_dst(decode_idx_dst),
        .wb_valid(wb_valid), .wb_idx_dst(wb_idx_dst), .flush(flush),
        .stall(stall_n), .busy_mask(busy_n), .underflow_err(uf_n));

    typedef struct {
        logic        dv, u1, u2, wd, wv, fl;
        logic [4:0]  s1, s2, d, w;
        logic        st_b, st_n, uf;
        logic [31:0] busy;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(int dv, int u1, int s1, int u2, int s2, int wd, int d,
                                int wv, int w, int fl, int st_b, int st_n,
                                logic [31:0] busy, int uf);
        vec_t v;
        v.dv = (dv != 0); v.u1 = (u1 != 0); v.u2 = (u2 != 0); v.wd = (wd != 0);
        v.wv = (wv != 0); v.fl = (fl != 0);
        v.s1 = 5'(s1); v.s2 = 5'(s2); v.d = 5'(d); v.w = 5'(w);
        v.st_b = (st_b != 0); v.st_n = (st_n != 0); v.uf = (uf != 0);
        v.busy = busy;
        return v;
    endfunction

    function automatic logic [31:0] bit_of(int r);
        return 32'd1 << r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        decode_valid      = v.dv;
        decode_uses_src_1 = v.u1;  decode_idx_src_1 = v.s1;
        decode_uses_src_2 = v.u2;  decode_idx_src_2 = v.s2;
        decode_writes_dst = v.wd;  decode_idx_dst   = v.d;
        wb_valid          = v.wv;  wb_idx_dst       = v.w;
        flush             = v.fl;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        vec_t e;
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk($sformatf("v%0d queue_empty", n), 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d stall_bypass", n), 32'(stall_b), 32'(e.st_b));
            chk($sformatf("v%0d stall_nobypass", n), 32'(stall_n), 32'(e.st_n));
            chk($sformatf("v%0d busy_bypass", n), busy_b, e.busy);
            chk($sformatf("v%0d busy_nobypass", n), busy_n, e.busy);
            chk($sformatf("v%0d uf_bypass", n), 32'(uf_b), 32'(e.uf));
            chk($sformatf("v%0d uf_nobypass", n), 32'(uf_n), 32'(e.uf));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          dv u1 s1 u2 s2 wd d  wv w  fl stB stN busy                    uf
        // RAW on x5
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 32'd0, 0));
        vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, bit_of(5), 0));
        vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, bit_of(5), 0));
        vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 0, 1, bit_of(5), 0));
        vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0));
        // Saturation on x7
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 32'd0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, bit_of(7), 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, bit_of(7), 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 1, bit_of(7), 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0, 0, bit_of(7), 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 1, bit_of(7), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, bit_of(7), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, bit_of(7), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, bit_of(7), 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0));
        // Flush and x0
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 32'd0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, bit_of(9), 0));
        vecs.push_back(mk(1, 1, 9, 0, 0, 1, 11, 0, 0, 1, 0, 0, bit_of(9) | bit_of(10), 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'd0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'd0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0));
        // Underflow on x12
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 32'd0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1));
        // Source-2 hazard; an unused source 1 with a busy index must not stall
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 32'd0, 1));
        vecs.push_back(mk(1, 0, 3, 1, 3, 0, 0, 0, 0, 0, 1, 1, bit_of(3), 1));
        vecs.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, bit_of(3), 1));
        vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 0, 1, bit_of(3), 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1));

        // Reset with a would-be hazard on decode
        drive(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0));
        rst = 1'b1;
        #1;
        chk("reset stall_bypass", 32'(stall_b), 32'd0);
        chk("reset stall_nobypass", 32'(stall_n), 32'd0);
        chk("reset busy", busy_b, 32'd0);
        chk("reset uf", 32'(uf_b), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset asserted mid-stall drops stall immediately and clears all tracking
        @(posedge clk);
        #1;
        drive(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 32'd0, 0));
        @(posedge clk);
        #1;
        drive(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 0));
        @(negedge clk);
        chk("midrst pre stall", 32'(stall_b), 32'd1);
        chk("midrst pre busy", busy_b, bit_of(6));
        chk("midrst pre uf", 32'(uf_b), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst stall_bypass", 32'(stall_b), 32'd0);
        chk("midrst stall_nobypass", 32'(stall_n), 32'd0);
        chk("midrst busy", busy_n, 32'd0);
        chk("midrst uf", 32'(uf_n), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst stall", 32'(stall_b), 32'd0);
        chk("postrst busy", busy_b, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
